// File: rtl/fc_result_pingpong_buffer_if.sv
// Bus bundle between the FC score writer, the ping-pong result store and the host reader.
interface fc_result_pingpong_buffer_if #(
  parameter int unsigned AF         = 3,
  parameter int unsigned BATCH      = 9,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FOUT       = 1000,
  parameter int unsigned ADDR_WIDTH = 32
);
  localparam int unsigned IW = (FOUT > 1) ? $clog2(FOUT) : 1;

  logic                                       wr_valid;
  logic                                       wr_ready;
  logic [BATCH-1:0][AF-1:0][DATA_WIDTH-1:0]   wr_data;
  logic                                       result_valid;
  logic                                       rd_en;
  logic [ADDR_WIDTH-1:0]                      rd_addr;
  logic [BATCH-1:0][AF-1:0][DATA_WIDTH-1:0]   result_data;
  logic                                       rd_data_vld;
  logic                                       rd_err;
  logic                                       result_ready;
  logic [BATCH-1:0][IW-1:0]                   argmax_idx;

  modport master (
    output wr_valid, wr_data, rd_en, rd_addr, result_ready,
    input  wr_ready, result_valid, result_data, rd_data_vld, rd_err, argmax_idx
  );

  modport slave (
    input  wr_valid, wr_data, rd_en, rd_addr, result_ready,
    output wr_ready, result_valid, result_data, rd_data_vld, rd_err, argmax_idx
  );
endinterface

// File: rtl/fc_result_pingpong_buffer.sv
// Two-bank FC result store: FC fills one bank while the host reads the other,
// with a per-batch argmax tracked during the fill and latched when the bank becomes full.
module fc_result_pingpong_buffer #(
  parameter int unsigned AF         = 3,
  parameter int unsigned BATCH      = 9,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FOUT       = 1000,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned ARGMAX_EN  = 1
) (
  input  logic                        clk,
  input  logic                        rstn,
  fc_result_pingpong_buffer_if.slave  bus
);
  localparam int unsigned DEPTH = (FOUT + AF - 1) / AF;
  localparam int unsigned CW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned IW    = (FOUT > 1) ? $clog2(FOUT) : 1;

  localparam logic [1:0] S_EMPTY   = 2'd0;
  localparam logic [1:0] S_FILLING = 2'd1;
  localparam logic [1:0] S_FULL    = 2'd2;

  typedef logic [BATCH-1:0][AF-1:0][DATA_WIDTH-1:0] word_t;
  typedef logic [BATCH-1:0][IW-1:0]                 amax_t;

  logic [1:0]                   r_state [2];
  logic [1:0]                   w_state_nxt [2];
  logic                         r_wr_bank, w_wr_bank_nxt;
  logic                         r_rd_bank, w_rd_bank_nxt;
  logic [CW-1:0]                r_wr_cnt, w_wr_cnt_nxt;
  word_t                        r_mem [2][DEPTH];
  logic signed [DATA_WIDTH-1:0] r_run_max [BATCH];
  logic signed [DATA_WIDTH-1:0] w_run_max_nxt [BATCH];
  logic [IW-1:0]                r_run_idx [BATCH];
  logic [IW-1:0]                w_run_idx_nxt [BATCH];
  amax_t                        r_amax [2];
  amax_t                        w_amax_nxt [2];

  logic  r_wr_ready, w_wr_ready_nxt;
  logic  r_result_valid, w_result_valid_nxt;
  amax_t r_argmax_idx, w_argmax_idx_nxt;
  logic  r_rd_data_vld, r_rd_err;
  word_t r_result_data;

  logic w_wr_fire, w_release, w_last_beat, w_rd_in_range, w_rd_hit, w_rd_oob;

  assign w_wr_fire     = bus.wr_valid & r_wr_ready;
  assign w_release     = bus.result_ready & r_result_valid;
  assign w_last_beat   = (r_wr_cnt == CW'(DEPTH - 1));
  assign w_rd_in_range = (bus.rd_addr < ADDR_WIDTH'(DEPTH));
  assign w_rd_hit      = bus.rd_en & r_result_valid & w_rd_in_range;
  assign w_rd_oob      = bus.rd_en & r_result_valid & ~w_rd_in_range;

  // Bank sequencing, running argmax and next values of the registered status outputs
  always_comb begin
    w_state_nxt   = r_state;
    w_wr_bank_nxt = r_wr_bank;
    w_rd_bank_nxt = r_rd_bank;
    w_wr_cnt_nxt  = r_wr_cnt;
    w_run_max_nxt = r_run_max;
    w_run_idx_nxt = r_run_idx;
    w_amax_nxt    = r_amax;

    if (w_wr_fire) begin
      if (w_last_beat) begin
        w_state_nxt[r_wr_bank] = S_FULL;
        w_wr_cnt_nxt           = '0;
        w_wr_bank_nxt          = ~r_wr_bank;
      end else begin
        w_state_nxt[r_wr_bank] = S_FILLING;
        w_wr_cnt_nxt           = r_wr_cnt + CW'(1);
      end
      if (ARGMAX_EN != 0) begin
        for (int b = 0; b < int'(BATCH); b++) begin
          // Lowest lane first with strict '>' keeps the lowest index on ties; padding classes skipped
          for (int j = 0; j < int'(AF); j++) begin
            if ((32'(r_wr_cnt) * AF + 32'(j) < FOUT) &&
                (((r_wr_cnt == '0) && (j == 0)) ||
                 ($signed(bus.wr_data[b][j]) > w_run_max_nxt[b]))) begin
              w_run_max_nxt[b] = $signed(bus.wr_data[b][j]);
              w_run_idx_nxt[b] = IW'(32'(r_wr_cnt) * AF + 32'(j));
            end
          end
          if (w_last_beat) w_amax_nxt[r_wr_bank][b] = w_run_idx_nxt[b];
        end
      end
    end

    if (w_release) begin
      w_state_nxt[r_rd_bank] = S_EMPTY;
      w_rd_bank_nxt          = ~r_rd_bank;
    end

    w_wr_ready_nxt     = (w_state_nxt[w_wr_bank_nxt] != S_FULL);
    w_result_valid_nxt = (w_state_nxt[w_rd_bank_nxt] == S_FULL);
    w_argmax_idx_nxt   = (w_result_valid_nxt && (ARGMAX_EN != 0)) ? w_amax_nxt[w_rd_bank_nxt] : '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state        <= '{default: S_EMPTY};
      r_wr_bank      <= 1'b0;
      r_rd_bank      <= 1'b0;
      r_wr_cnt       <= '0;
      r_run_max      <= '{default: '0};
      r_run_idx      <= '{default: '0};
      r_amax         <= '{default: '0};
      r_wr_ready     <= 1'b1;
      r_result_valid <= 1'b0;
      r_argmax_idx   <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_wr_bank      <= w_wr_bank_nxt;
      r_rd_bank      <= w_rd_bank_nxt;
      r_wr_cnt       <= w_wr_cnt_nxt;
      r_run_max      <= w_run_max_nxt;
      r_run_idx      <= w_run_idx_nxt;
      r_amax         <= w_amax_nxt;
      r_wr_ready     <= w_wr_ready_nxt;
      r_result_valid <= w_result_valid_nxt;
      r_argmax_idx   <= w_argmax_idx_nxt;
    end
  end

  // Score storage needs no reset: a bank is only readable after a complete fill
  always_ff @(posedge clk) begin
    if (w_wr_fire) r_mem[r_wr_bank][r_wr_cnt] <= bus.wr_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_result_data <= '0;
      r_rd_data_vld <= 1'b0;
      r_rd_err      <= 1'b0;
    end else begin
      r_rd_data_vld <= w_rd_hit;
      r_rd_err      <= w_rd_oob;
      if (w_rd_hit)      r_result_data <= r_mem[r_rd_bank][bus.rd_addr[CW-1:0]];
      else if (w_rd_oob) r_result_data <= '0;
    end
  end

  assign bus.wr_ready     = r_wr_ready;
  assign bus.result_valid = r_result_valid;
  assign bus.result_data  = r_result_data;
  assign bus.rd_data_vld  = r_rd_data_vld;
  assign bus.rd_err       = r_rd_err;
  assign bus.argmax_idx   = r_argmax_idx;
endmodule

// File: tb/tb_fc_result_pingpong_buffer.sv
// Self-checking bench: small configuration (FOUT=10, AF=3 -> 4 words/bank) against a
// queue-of-full-images reference model with a direct linear argmax.
module tb_fc_result_pingpong_buffer;
  localparam int AF    = 3;
  localparam int BATCH = 4;
  localparam int DW    = 8;
  localparam int FOUT  = 10;
  localparam int AW    = 32;
  localparam int DEPTH = 4;
  localparam int IW    = 4;

  typedef logic [BATCH-1:0][AF-1:0][DW-1:0]             word_t;
  typedef logic [DEPTH-1:0][BATCH-1:0][AF-1:0][DW-1:0]  img_t;
  typedef logic [BATCH-1:0][IW-1:0]                     amax_t;

  logic clk;
  logic rstn;

  fc_result_pingpong_buffer_if #(.AF(AF), .BATCH(BATCH), .DATA_WIDTH(DW), .FOUT(FOUT),
                                 .ADDR_WIDTH(AW)) bus ();

  fc_result_pingpong_buffer #(.AF(AF), .BATCH(BATCH), .DATA_WIDTH(DW), .FOUT(FOUT),
                              .ADDR_WIDTH(AW), .ARGMAX_EN(1)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    vec  = 0;
  int    miss = 0;
  img_t  q[$];
  img_t  cur;
  int    cur_cnt = 0;
  logic  exp_vld = 1'b0;
  logic  exp_err = 1'b0;
  word_t exp_data = '0;

  // Linear scan over the real classes only; first maximum wins
  function automatic amax_t ref_amax(input img_t im);
    amax_t r;
    int best;
    logic signed [DW-1:0] bv, s;
    r = '0;
    for (int b = 0; b < BATCH; b++) begin
      best = 0;
      bv   = $signed(im[0][b][0]);
      for (int i = 1; i < FOUT; i++) begin
        s = $signed(im[i / AF][b][i % AF]);
        if (s > bv) begin bv = s; best = i; end
      end
      r[b] = IW'(best);
    end
    return r;
  endfunction

  function automatic amax_t exp_argmax();
    if (q.size() == 0) return '0;
    return ref_amax(q[0]);
  endfunction

  function automatic img_t rand_img();
    img_t im;
    for (int w = 0; w < DEPTH; w++)
      for (int b = 0; b < BATCH; b++)
        for (int j = 0; j < AF; j++) im[w][b][j] = DW'($urandom);
    return im;
  endfunction

  task automatic idle();
    bus.wr_valid = 1'b0; bus.wr_data = '0; bus.rd_en = 1'b0;
    bus.rd_addr = '0; bus.result_ready = 1'b0;
  endtask

  // Apply the currently driven inputs to the model, then advance one clock
  task automatic step();
    logic rv, wrdy;
    rv   = (q.size() > 0);
    wrdy = (q.size() < 2);
    exp_vld = 1'b0;
    exp_err = 1'b0;
    if (bus.rd_en && rv) begin
      if (bus.rd_addr < 32'(DEPTH)) begin
        exp_vld  = 1'b1;
        exp_data = q[0][int'(bus.rd_addr)];
      end else begin
        exp_err  = 1'b1;
        exp_data = '0;
      end
    end
    if (bus.wr_valid && wrdy) begin
      cur[cur_cnt] = bus.wr_data;
      cur_cnt++;
    end
    if (bus.result_ready && rv) void'(q.pop_front());
    if (cur_cnt == DEPTH) begin
      q.push_back(cur);
      cur_cnt = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    q.delete();
    cur_cnt = 0; exp_vld = 1'b0; exp_err = 1'b0; exp_data = '0;
  endtask

  task automatic do_reset();
    idle();
    rstn = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic write_image(input img_t im, input int nbeats);
    for (int w = 0; w < nbeats; w++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = im[w];
      step();
    end
    bus.wr_valid = 1'b0;
  endtask

  task automatic release_bank();
    bus.result_ready = 1'b1;
    step();
    bus.result_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vec++; if (bus.wr_ready !== 1'b1) begin miss++; $display("FAIL reset_wr_ready got %b want 1", bus.wr_ready); end
    vec++; if (bus.result_valid !== 1'b0) begin miss++; $display("FAIL reset_result_valid got %b want 0", bus.result_valid); end
    vec++; if (bus.rd_data_vld !== 1'b0 || bus.rd_err !== 1'b0) begin miss++; $display("FAIL reset_vld_err got %b%b want 00", bus.rd_data_vld, bus.rd_err); end
    vec++; if (bus.argmax_idx !== '0 || bus.result_data !== '0) begin miss++; $display("FAIL reset_data got %h/%h want 0", bus.argmax_idx, bus.result_data); end
  endtask

  task automatic test_fill_read();
    img_t im;
    word_t w2;
    for (int w = 0; w < DEPTH; w++)
      for (int b = 0; b < BATCH; b++)
        for (int j = 0; j < AF; j++) im[w][b][j] = DW'(w * AF + j);
    for (int w = 0; w < DEPTH; w++) begin
      bus.wr_valid = 1'b1; bus.wr_data = im[w];
      step();
      vec++; if (bus.result_valid !== (q.size() > 0)) begin miss++; $display("FAIL fill_result_valid beat %0d got %b want %b", w, bus.result_valid, q.size() > 0); end
    end
    bus.wr_valid = 1'b0;
    vec++; if (bus.result_valid !== 1'b1) begin miss++; $display("FAIL fill_valid_after_last got %b want 1", bus.result_valid); end
    bus.rd_en = 1'b1; bus.rd_addr = 32'd2;
    step();
    bus.rd_en = 1'b0;
    w2 = bus.result_data;
    vec++; if (bus.rd_data_vld !== 1'b1) begin miss++; $display("FAIL fill_rd_vld got %b want 1", bus.rd_data_vld); end
    vec++; if (bus.result_data !== exp_data) begin miss++; $display("FAIL fill_rd_data got %h want %h", bus.result_data, exp_data); end
    vec++; if (w2[0][0] !== 8'd6 || w2[0][1] !== 8'd7 || w2[0][2] !== 8'd8) begin miss++; $display("FAIL fill_rd_678 got %h want 080706", w2[0]); end
    vec++; if (bus.argmax_idx !== exp_argmax() || bus.argmax_idx[0] !== 4'd9) begin miss++; $display("FAIL fill_argmax got %h want %h", bus.argmax_idx, exp_argmax()); end
    step();
    vec++; if (bus.rd_data_vld !== 1'b0) begin miss++; $display("FAIL fill_vld_pulse got %b want 0", bus.rd_data_vld); end
    release_bank();
    vec++; if (bus.result_valid !== 1'b0 || bus.argmax_idx !== '0) begin miss++; $display("FAIL fill_release got %b/%h want 0/0", bus.result_valid, bus.argmax_idx); end
  endtask

  task automatic test_padding();
    img_t im;
    amax_t want;
    for (int i = 0; i < DEPTH * AF; i++)
      for (int b = 0; b < BATCH; b++)
        im[i / AF][b][i % AF] = DW'($urandom_range(0, 227) - 128);
    for (int b = 0; b < BATCH; b++) begin
      im[1][b][1] = 8'd100;
      im[3][b][1] = 8'd127;
      im[3][b][2] = 8'd127;
    end
    write_image(im, DEPTH);
    for (int b = 0; b < BATCH; b++) want[b] = 4'd4;
    vec++; if (bus.argmax_idx !== want || bus.argmax_idx !== exp_argmax()) begin miss++; $display("FAIL padding_argmax got %h want %h", bus.argmax_idx, want); end
    release_bank();
  endtask

  task automatic test_ties();
    img_t im;
    amax_t want;
    for (int i = 0; i < DEPTH * AF; i++)
      for (int b = 0; b < BATCH; b++)
        im[i / AF][b][i % AF] = DW'($urandom_range(0, 126) - 128);
    for (int b = 0; b < BATCH; b++) begin
      im[1][b][0] = 8'hFF;
      im[2][b][1] = 8'hFF;
    end
    write_image(im, DEPTH);
    for (int b = 0; b < BATCH; b++) want[b] = 4'd3;
    vec++; if (bus.argmax_idx !== want || bus.argmax_idx !== exp_argmax()) begin miss++; $display("FAIL ties_argmax got %h want %h", bus.argmax_idx, want); end
    release_bank();
  endtask

  task automatic test_backpressure();
    img_t a, b, c;
    int addr;
    a = rand_img(); b = rand_img(); c = rand_img();
    write_image(a, DEPTH);
    write_image(b, DEPTH);
    vec++; if (bus.wr_ready !== 1'b0 || bus.result_valid !== 1'b1) begin miss++; $display("FAIL bp_full got rdy=%b vld=%b want 0/1", bus.wr_ready, bus.result_valid); end
    bus.wr_valid = 1'b1; bus.wr_data = c[0];
    repeat (3) begin
      step();
      vec++; if (bus.wr_ready !== 1'b0) begin miss++; $display("FAIL bp_hold got %b want 0", bus.wr_ready); end
    end
    bus.result_ready = 1'b1;
    step();
    bus.result_ready = 1'b0;
    vec++; if (bus.wr_ready !== 1'b1 || bus.result_valid !== 1'b1) begin miss++; $display("FAIL bp_release got rdy=%b vld=%b want 1/1", bus.wr_ready, bus.result_valid); end
    vec++; if (bus.argmax_idx !== ref_amax(b)) begin miss++; $display("FAIL bp_argmax_b got %h want %h", bus.argmax_idx, ref_amax(b)); end
    for (int w = 0; w < DEPTH; w++) begin
      bus.wr_data = c[w];
      step();
    end
    bus.wr_valid = 1'b0;
    vec++; if (bus.wr_ready !== 1'b0) begin miss++; $display("FAIL bp_refull got %b want 0", bus.wr_ready); end
    addr = $urandom_range(0, DEPTH - 1);
    bus.rd_en = 1'b1; bus.rd_addr = AW'(addr);
    step();
    bus.rd_en = 1'b0;
    vec++; if (bus.rd_data_vld !== 1'b1 || bus.result_data !== b[addr]) begin miss++; $display("FAIL bp_read_b got %b/%h want 1/%h", bus.rd_data_vld, bus.result_data, b[addr]); end
  endtask

  task automatic test_boundary();
    bus.rd_en = 1'b1; bus.rd_addr = AW'(DEPTH);
    step();
    vec++; if (bus.rd_err !== 1'b1 || bus.rd_data_vld !== 1'b0 || bus.result_data !== '0) begin miss++; $display("FAIL oob_depth got err=%b vld=%b data=%h want 1/0/0", bus.rd_err, bus.rd_data_vld, bus.result_data); end
    bus.rd_addr = AW'($urandom) | 32'h8000_0000;
    step();
    vec++; if (bus.rd_err !== exp_err || bus.rd_err !== 1'b1) begin miss++; $display("FAIL oob_large got %b want 1", bus.rd_err); end
    bus.rd_en = 1'b0;
    step();
    vec++; if (bus.rd_err !== 1'b0) begin miss++; $display("FAIL oob_pulse got %b want 0", bus.rd_err); end
    release_bank();
    release_bank();
    bus.rd_en = 1'b1; bus.rd_addr = 32'd1; bus.result_ready = 1'b1;
    repeat (2) begin
      step();
      vec++; if (bus.rd_data_vld !== 1'b0 || bus.rd_err !== 1'b0) begin miss++; $display("FAIL empty_read got vld=%b err=%b want 0/0", bus.rd_data_vld, bus.rd_err); end
      vec++; if (bus.result_valid !== 1'b0 || bus.wr_ready !== 1'b1) begin miss++; $display("FAIL empty_state got vld=%b rdy=%b want 0/1", bus.result_valid, bus.wr_ready); end
      bus.rd_addr = AW'(DEPTH);
    end
    idle();
  endtask

  task automatic test_simultaneous();
    img_t a, b, d;
    int addr;
    do_reset();
    a = rand_img(); b = rand_img(); d = rand_img();
    write_image(a, DEPTH);
    write_image(b, DEPTH - 1);
    bus.wr_valid = 1'b1; bus.wr_data = b[DEPTH-1]; bus.result_ready = 1'b1;
    step();
    idle();
    vec++; if (bus.result_valid !== 1'b1 || bus.wr_ready !== 1'b1) begin miss++; $display("FAIL simul_flags got vld=%b rdy=%b want 1/1", bus.result_valid, bus.wr_ready); end
    vec++; if (bus.argmax_idx !== ref_amax(b) || bus.argmax_idx !== exp_argmax()) begin miss++; $display("FAIL simul_argmax got %h want %h", bus.argmax_idx, ref_amax(b)); end
    addr = $urandom_range(0, DEPTH - 1);
    bus.rd_en = 1'b1; bus.rd_addr = AW'(addr);
    step();
    bus.rd_en = 1'b0;
    vec++; if (bus.result_data !== b[addr] || bus.rd_data_vld !== 1'b1) begin miss++; $display("FAIL simul_read got %h want %h", bus.result_data, b[addr]); end
    release_bank();
    write_image(d, 2);
    rstn = 1'b0;
    #2;
    vec++; if (bus.wr_ready !== 1'b1 || bus.result_valid !== 1'b0 || bus.rd_data_vld !== 1'b0 || bus.rd_err !== 1'b0) begin miss++; $display("FAIL midreset_flags got rdy=%b vld=%b want 1/0", bus.wr_ready, bus.result_valid); end
    vec++; if (bus.result_data !== '0 || bus.argmax_idx !== '0) begin miss++; $display("FAIL midreset_data got %h/%h want 0", bus.result_data, bus.argmax_idx); end
    clear_model();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    write_image(d, DEPTH);
    vec++; if (bus.result_valid !== 1'b1 || bus.argmax_idx !== ref_amax(d)) begin miss++; $display("FAIL midreset_refill got %b/%h want 1/%h", bus.result_valid, bus.argmax_idx, ref_amax(d)); end
    release_bank();
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      bus.wr_valid     = ($urandom_range(0, 9) < 7);
      bus.wr_data      = word_t'({$urandom, $urandom, $urandom});
      bus.rd_en        = ($urandom_range(0, 1) == 1);
      bus.rd_addr      = AW'($urandom_range(0, DEPTH + 1));
      bus.result_ready = ($urandom_range(0, 9) < 2);
      step();
      vec++; if (bus.wr_ready !== (q.size() < 2) || bus.result_valid !== (q.size() > 0)) begin miss++; $display("FAIL rand_flags cyc %0d got rdy=%b vld=%b want %b/%b", n, bus.wr_ready, bus.result_valid, q.size() < 2, q.size() > 0); end
      vec++; if (bus.argmax_idx !== exp_argmax()) begin miss++; $display("FAIL rand_argmax cyc %0d got %h want %h", n, bus.argmax_idx, exp_argmax()); end
      vec++; if (bus.rd_data_vld !== exp_vld || bus.rd_err !== exp_err) begin miss++; $display("FAIL rand_vld_err cyc %0d got %b%b want %b%b", n, bus.rd_data_vld, bus.rd_err, exp_vld, exp_err); end
      if (exp_vld || exp_err) begin
        vec++; if (bus.result_data !== exp_data) begin miss++; $display("FAIL rand_data cyc %0d got %h want %h", n, bus.result_data, exp_data); end
      end
    end
    idle();
  endtask

  initial begin
    rstn = 1'b0;
    idle();
    test_reset();
    test_fill_read();
    test_padding();
    test_ties();
    test_backpressure();
    test_boundary();
    test_simultaneous();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
